rvfi_bus_fairness: RTL

- Parametrised bus-fairness monitor for riscv-formal core wrappers.
- Generalises the per-wrapper iBus/dBus pending-cycle counters to CHANNELS independent cmd/rsp channels.
- Each channel gets:
  - bounded command-stall and response-latency counters;
  - outstanding-read tracking with protocol-error detection.
- Produces a single `fair` qualifier that the wrapper feeds to restrict/assume, so the solver only explores traces with bounded bus latency.

---
 rtl/rvfi_bus_fairness.sv | 102 ++++++++++
 1 files changed

// File: rtl/rvfi_bus_fairness.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rvfi_bus_fairness                                           |
// | Purpose  : Per-channel cmd/rsp latency and outstanding-read monitor    |
// |            producing a single bounded-latency `fair` qualifier.        |
// |            Optional macro RVFI_FAIRNESS_ASSUME_EN emits restrict(fair).|
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module rvfi_bus_fairness #(
  parameter int CHANNELS        = 2,
  parameter int CNT_W           = 3,
  parameter int MAX_CMD_WAIT    = 4,
  parameter int MAX_RSP_WAIT    = 4,
  parameter int MAX_OUTSTANDING = 1,
  parameter int OUT_W           = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       cmd_valid,
  input  logic [CHANNELS-1:0]       cmd_ready,
  input  logic [CHANNELS-1:0]       cmd_wr,
  input  logic [CHANNELS-1:0]       rsp_valid,
  input  logic                      trap,
  output logic                      fair,
  output logic [CHANNELS-1:0]       cmd_stall_err,
  output logic [CHANNELS-1:0]       rsp_stall_err,
  output logic [CHANNELS-1:0]       proto_err,
  output logic [CHANNELS*OUT_W-1:0] outstanding
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CMD_LIM = CNT_W'(MAX_CMD_WAIT);
  localparam logic [CNT_W-1:0] c_RSP_LIM = CNT_W'(MAX_RSP_WAIT);
  localparam logic [OUT_W-1:0] c_OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] r_cmd_cnt;
    logic [CNT_W-1:0] r_rsp_cnt;
    logic [OUT_W-1:0] r_out;
    logic             r_proto;
    logic             w_stall;
    logic             w_rd_acc;
    logic             w_rsp;
    logic             w_rsp_wait;

    assign w_stall    = cmd_valid[g] & ~cmd_ready[g];
    assign w_rd_acc   = cmd_valid[g] & cmd_ready[g] & ~cmd_wr[g];
    assign w_rsp      = rsp_valid[g];
    assign w_rsp_wait = (r_out != '0) & ~w_rsp;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_cmd_cnt <= '0;
        r_rsp_cnt <= '0;
        r_out     <= '0;
        r_proto   <= 1'b0;
      end else begin
        if (w_stall)
          r_cmd_cnt <= (r_cmd_cnt == c_CNT_MAX) ? r_cmd_cnt : r_cmd_cnt + 1'b1;
        else
          r_cmd_cnt <= '0;

        if (w_rsp_wait)
          r_rsp_cnt <= (r_rsp_cnt == c_CNT_MAX) ? r_rsp_cnt : r_rsp_cnt + 1'b1;
        else
          r_rsp_cnt <= '0;

        // A simultaneous accept and response cancel; errors hold the count
        // at its bound instead of wrapping.
        case ({w_rd_acc, w_rsp})
          2'b10: begin
            if (r_out == c_OUT_MAX) r_proto <= 1'b1;
            else                    r_out   <= r_out + 1'b1;
          end
          2'b01: begin
            if (r_out == '0) r_proto <= 1'b1;
            else             r_out   <= r_out - 1'b1;
          end
          default: ;
        endcase
      end
    end

    assign cmd_stall_err[g]              = (r_cmd_cnt >= c_CMD_LIM);
    assign rsp_stall_err[g]              = (r_rsp_cnt >= c_RSP_LIM);
    assign proto_err[g]                  = r_proto;
    assign outstanding[g*OUT_W +: OUT_W] = r_out;
  end

  assign fair = reset ? 1'b1
                      : (~trap & ~|cmd_stall_err & ~|rsp_stall_err & ~|proto_err);

`ifdef RVFI_FAIRNESS_ASSUME_EN
  always @(posedge clock) begin
    if (!reset) restrict property (fair);
  end
`else
  // fair is exported only; the wrapper decides how to constrain with it.
`endif

endmodule
`default_nettype wire
